alu_cmd_sequencer: RTL

//  Initiator side of the alu interface. Buffers operation commands (a, b, s) from an upstream

---
 rtl/alu_cmd_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_sequencer
//  Purpose  : Initiator side of the alu interface. Buffers (a, b, s) commands
//             from a valid/ready source in a small FIFO, issues them one at a
//             time onto registered alu inputs, waits SETTLE cycles, captures
//             alu_z and returns it over a valid/ready response channel.
//  Ports    : clk, rst                  - clock, synchronous active-high reset
//             cmd_valid/cmd_ready       - command handshake (cmd_ready = !full)
//             cmd_a, cmd_b, cmd_s       - command operands and opcode
//             alu_a, alu_b, alu_s       - registered drive to the alu
//             alu_z                     - combinational alu result
//             rsp_valid/rsp_ready       - response handshake
//             rsp_z, rsp_s              - captured result and its opcode
//             busy                      - FIFO non-empty or FSM not idle
//             rsp_cnt                   - completed responses, wraps at 256
//  Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
    parameter int WIDTH  = 8,
    parameter int SEL_W  = 3,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [SEL_W-1:0] cmd_s,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_s,
    input  logic [WIDTH-1:0] alu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_z,
    output logic [SEL_W-1:0] rsp_s,
    output logic             busy,
    output logic [7:0]       rsp_cnt
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);
    localparam logic [3:0]         c_SETTLE   = 4'(SETTLE);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DRIVE = 2'd1;
    localparam logic [1:0] c_ST_RESP  = 2'd2;

    // ------------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]   r_mem_a [DEPTH];
    logic [WIDTH-1:0]   r_mem_b [DEPTH];
    logic [SEL_W-1:0]   r_mem_s [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_head_valid;

    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_capture;
    logic               w_rsp_done;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [3:0]         r_settle_cnt;

    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [SEL_W-1:0]   r_alu_s;
    logic               r_rsp_valid;
    logic [WIDTH-1:0]   r_rsp_z;
    logic [SEL_W-1:0]   r_rsp_s;
    logic [7:0]         r_rsp_cnt;

    assign w_full = (r_count == c_CNT_FULL);
    // A full FIFO refuses pushes even in a cycle that pops.
    assign w_push = cmd_valid && !w_full;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= cmd_a;
            r_mem_b[r_wr_ptr] <= cmd_b;
            r_mem_s[r_wr_ptr] <= cmd_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_head_valid <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            // Issue eligibility lags occupancy by one cycle: an entry written
            // at edge E is first issued at E+2, keeping the issue decision
            // off the upstream push path. After a pop the FSM spends at least
            // two cycles outside IDLE, so the lag never issues a stale entry.
            r_head_valid <= (r_count != '0);
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_next;
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (r_head_valid && (r_count != '0)) w_state_next = c_ST_DRIVE;
            c_ST_DRIVE: if (r_settle_cnt == 4'd1)             w_state_next = c_ST_RESP;
            c_ST_RESP:  if (rsp_ready)                        w_state_next = c_ST_IDLE;
            default:                                          w_state_next = c_ST_IDLE;
        endcase
    end

    // FSM: outputs (datapath strobes)
    always_comb begin
        w_pop      = 1'b0;
        w_capture  = 1'b0;
        w_rsp_done = 1'b0;
        case (r_state)
            c_ST_IDLE:  w_pop      = r_head_valid && (r_count != '0);
            c_ST_DRIVE: w_capture  = (r_settle_cnt == 4'd1);
            c_ST_RESP:  w_rsp_done = r_rsp_valid && rsp_ready;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: alu drive, settle counter, response capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_s      <= '0;
            r_settle_cnt <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_z      <= '0;
            r_rsp_s      <= '0;
            r_rsp_cnt    <= '0;
        end else begin
            // alu inputs move only on an issue, so z is stable in DRIVE/RESP.
            if (w_pop) begin
                r_alu_a      <= r_mem_a[r_rd_ptr];
                r_alu_b      <= r_mem_b[r_rd_ptr];
                r_alu_s      <= r_mem_s[r_rd_ptr];
                r_rsp_s      <= r_mem_s[r_rd_ptr];
                r_settle_cnt <= c_SETTLE;
            end else if (r_state == c_ST_DRIVE) begin
                r_settle_cnt <= r_settle_cnt - 4'd1;
            end
            if (w_capture) begin
                r_rsp_z     <= alu_z;
                r_rsp_valid <= 1'b1;
            end
            if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
                r_rsp_cnt   <= r_rsp_cnt + 8'd1;
            end
        end
    end

    assign cmd_ready = !w_full;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_s     = r_alu_s;
    assign rsp_valid = r_rsp_valid;
    assign rsp_z     = r_rsp_z;
    assign rsp_s     = r_rsp_s;
    assign rsp_cnt   = r_rsp_cnt;
    assign busy      = (r_count != '0) || (r_state != c_ST_IDLE);

endmodule
`default_nettype wire
